// File: rtl/xalu_seq.sv
// Multi-cycle multiply/divide sequencer owning HI/LO (fixed-latency multiply, radix-2 restoring divide).
// Define XALU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (8-11).
module xalu_seq #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_result,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU  = 4'd4,
                           OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MUL  = 4'd7, OP_MADD  = 4'd8,
                           OP_MADDU = 4'd9, OP_MSUB  = 4'd10, OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

    state_t      state, state_nxt;
    logic        accept, is_mul, is_div, op_sgn;
    logic [1:0]  mode_nxt, mode;  // 0 write HI/LO, 1 MUL result, 2 accumulate add, 3 accumulate sub
    logic [31:0] a_q, b_q, quo, rem;
    logic [4:0]  cnt;
    logic        mul_sgn, dz, neg_q, negr_q;
    logic [63:0] ma, mb, prod;
    logic [32:0] rem_sh, diff;

    assign accept = start && !cancel && (state == IDLE);
    assign op_sgn = (op == OP_MULT) || (op == OP_MUL) || (op == OP_DIV) ||
                    (op == OP_MADD) || (op == OP_MSUB);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        is_mul   = 1'b0;
        mode_nxt = 2'd0;
        case (op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_MUL: begin is_mul = 1'b1; mode_nxt = 2'd1; end
`ifdef XALU_MADD_EN
            OP_MADD, OP_MADDU: begin is_mul = 1'b1; mode_nxt = 2'd2; end
            OP_MSUB, OP_MSUBU: begin is_mul = 1'b1; mode_nxt = 2'd3; end
`endif
            default: ;
        endcase
    end

    // Low 64 bits of the product of sign/zero-extended operands serve both signednesses.
    assign ma   = {{32{mul_sgn & a_q[31]}}, a_q};
    assign mb   = {{32{mul_sgn & b_q[31]}}, b_q};
    assign prod = ma * mb;

    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_nxt = MUL;
                else if (accept && is_div) state_nxt = (src_b == 32'd0) ? DIV_FIX : DIV;
            end
            MUL:     if (cnt == 5'd0) state_nxt = IDLE;
            DIV:     if (cnt == 5'd0) state_nxt = DIV_FIX;
            DIV_FIX: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0; lo <= '0; mul_result <= '0; done <= 1'b0;
            a_q <= '0; b_q <= '0; quo <= '0; rem <= '0; cnt <= '0;
            mode <= '0; mul_sgn <= 1'b0; dz <= 1'b0; neg_q <= 1'b0; negr_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_MTHI) hi <= src_a;
                    if (op == OP_MTLO) lo <= src_a;
                    if (is_mul) begin
                        a_q     <= src_a;
                        b_q     <= src_b;
                        mul_sgn <= op_sgn;
                        mode    <= mode_nxt;
                        cnt     <= 5'(MUL_LAT - 1);
                    end
                    if (is_div) begin
                        // Divide on magnitudes; signs fixed up in DIV_FIX.
                        a_q    <= src_a;
                        quo    <= (op_sgn && src_a[31]) ? -src_a : src_a;
                        b_q    <= (op_sgn && src_b[31]) ? -src_b : src_b;
                        rem    <= '0;
                        cnt    <= 5'd31;
                        dz     <= (src_b == 32'd0);
                        neg_q  <= op_sgn && (src_a[31] ^ src_b[31]);
                        negr_q <= op_sgn && src_a[31];
                    end
                end
                MUL: begin
                    if (cnt == 5'd0) begin
                        done <= 1'b1;
                        case (mode)
                            2'd0: {hi, lo} <= prod;
                            2'd1: mul_result <= prod[31:0];
`ifdef XALU_MADD_EN
                            2'd2: {hi, lo} <= {hi, lo} + prod;
                            2'd3: {hi, lo} <= {hi, lo} - prod;
`endif
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV: begin
                    rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
                    quo <= {quo[30:0], ~diff[32]};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                DIV_FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= a_q;
                    end else begin
                        lo <= neg_q  ? -quo : quo;
                        hi <= negr_q ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xalu_seq.sv
// Directed self-checking bench for xalu_seq (MUL_LAT=3); honours XALU_MADD_EN like the RTL.
module tb_xalu_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] mul_result, hi, lo;

    int n_pass = 0, n_total = 0;

    xalu_seq #(.MUL_LAT(3)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .done(done), .mul_result(mul_result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    // Present an op for exactly one rising edge; returns at the negedge after that edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        @(negedge clk);
        chk("proto_idle", 32'(busy), 32'd0);
        start = 1'b1; op = o; src_a = a; src_b = b; cancel = c;
        @(negedge clk);
        start = 1'b0; op = 4'd0; cancel = 1'b0;
    endtask

    // Count busy cycles from the current negedge, then expect a one-cycle done pulse.
    task automatic wait_op(input string tag, input int exp_busy);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
        chk({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mulres", mul_result, 32'd0);
        @(negedge clk) resetn = 1'b1;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_op("mult", 3);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_op("multu", 3);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(4'd4, 32'd100, 32'd7, 1'b0);
        wait_op("divu", 33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_op("div_neg", 33);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_op("div_ovf", 33);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        issue(4'd4, 32'd5, 32'd0, 1'b0);
        wait_op("divz", 1);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd5);

        // MTHI then MTLO back to back
        @(negedge clk);
        start = 1'b1; op = 4'd5; src_a = 32'h1234;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", 32'(busy), 32'd0);
        op = 4'd6; src_a = 32'h5678;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mtlo_done", 32'(done), 32'd0);

        issue(4'd3, 32'd100, 32'd7, 1'b1);
        chk("cancel_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("cancel_done", 32'(done), 32'd0);
        chk("cancel_hi", hi, 32'h1234);
        chk("cancel_lo", lo, 32'h5678);

        issue(4'd4, 32'd100, 32'd7, 1'b0);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        wait_op("midcancel", 32);
        chk("midcancel_lo", lo, 32'd14);
        chk("midcancel_hi", hi, 32'd2);

        issue(4'd7, 32'd3, 32'd5, 1'b0);
        wait_op("mul35", 3);
        chk("mul35_res", mul_result, 32'd15);
        chk("mul35_hi", hi, 32'd2);
        chk("mul35_lo", lo, 32'd14);

        issue(4'd7, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_op("mulbig", 3);
        chk("mulbig_res", mul_result, 32'd0);
        chk("mulbig_hi", hi, 32'd2);
        chk("mulbig_lo", lo, 32'd14);

        // New op accepted while done is high
        issue(4'd2, 32'd6, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_lo", lo, 32'd42);
        start = 1'b1; op = 4'd5; src_a = 32'hABCD;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        chk("b2b_hi", hi, 32'hABCD);
        chk("b2b_done_end", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a divide
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk) resetn = 1'b1;

        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(4'd9, 32'd1, 32'd1, 1'b0);
`ifdef XALU_MADD_EN
        wait_op("maddu", 3);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("maddu_done", 32'(done), 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
